coin_change_seq: RTL and testbench

COIN_CHANGE_SEQ -- requirements
Module: coin_change_seq

---
 rtl/coin_change_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_coin_change_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/coin_change_seq.sv
// ---------------------------------------------------------------------------
// coin_change_seq
//
// Sequences a coin ejector to pay out a change amount greedily with quarters,
// dimes and nickels. Each coin is one ej_* request. The request is held until
// the ejector acknowledges it, and a fixed idle gap follows every coin.
//
// Ejector handshake:
//   The design raises exactly one of ej_quarter / ej_dime / ej_nickel and
//   holds it. The ejector answers with ej_ack=1 for one or more cycles. The
//   first cycle in which ej_ack is sampled high while a request is held
//   completes the coin, and the request drops on that same edge. ej_ack is
//   ignored whenever no request is held.
//
// Parameters:
//   GAP_CYCLES   idle cycles between consecutive coin requests (1..15)
//   ACK_TIMEOUT  cycles to wait for ej_ack before giving up (2..65535);
//                used only when COIN_TIMEOUT_EN is defined
//
// Build option:
//   COIN_TIMEOUT_EN  when defined, a request that is not acknowledged within
//                    ACK_TIMEOUT cycles is abandoned. err is set, the unpaid
//                    amount stays in rem_cents, and the request completes.
//                    When undefined, the sequencer waits forever for ej_ack.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous active-high reset
//   start         request to pay change_cents (sampled only when idle)
//   change_cents  amount in cents (0..100, multiple of 5 to be payable)
//   ej_ack        ejector acknowledge, one coin has left
//   ej_quarter    eject request for a 25c coin (registered)
//   ej_dime       eject request for a 10c coin (registered)
//   ej_nickel     eject request for a 5c coin (registered)
//   busy          high while a request is in progress
//   done          one-cycle pulse when a request completes
//   err           sticky error flag, cleared by reset or the next start
//   rem_cents     change still owed
//   coins_out     coins ejected for the current request (saturates at 15)
//   dbg_state     current FSM state encoding, for observation only
// ---------------------------------------------------------------------------
module coin_change_seq #(
    parameter int GAP_CYCLES  = 4,
    parameter int ACK_TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] change_cents,
    input  logic       ej_ack,
    output logic       ej_quarter,
    output logic       ej_dime,
    output logic       ej_nickel,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [6:0] rem_cents,
    output logic [3:0] coins_out,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_EJECT  = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t     state, state_nx;
    logic [6:0] rem_q, rem_nx;
    logic [3:0] coins_q, coins_nx;
    logic       err_q, err_nx;
    logic [2:0] ej_q, ej_nx;       // {quarter, dime, nickel}
    logic [3:0] gap_q, gap_nx;
    logic [6:0] coin_val;
    logic [2:0] pick;

`ifdef COIN_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);
    logic [15:0] tmo_q, tmo_nx;
`endif

    // Greedy choice for the amount still owed, one-hot {quarter, dime, nickel}.
    function automatic logic [2:0] pick_coin(input logic [6:0] rem);
        if (rem >= 7'd25)      pick_coin = 3'b100;
        else if (rem >= 7'd10) pick_coin = 3'b010;
        else                   pick_coin = 3'b001;
    endfunction

    function automatic logic payable(input logic [6:0] amt);
        payable = ((amt % 7'd5) == 7'd0) && (amt <= 7'd100);
    endfunction

    assign pick = pick_coin(rem_q);

    // Value of the coin currently being requested.
    always_comb begin
        coin_val = 7'd0;
        if (ej_q[2])      coin_val = 7'd25;
        else if (ej_q[1]) coin_val = 7'd10;
        else if (ej_q[0]) coin_val = 7'd5;
    end

    // Next-state and datapath logic.
    always_comb begin
        state_nx = state;
        rem_nx   = rem_q;
        coins_nx = coins_q;
        err_nx   = err_q;
        ej_nx    = ej_q;
        gap_nx   = gap_q;
`ifdef COIN_TIMEOUT_EN
        tmo_nx   = tmo_q;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    coins_nx = 4'd0;
                    // An unpayable amount still passes through SELECT with
                    // nothing owed, so it completes with the same latency
                    // as a zero amount and never ejects.
                    if (payable(change_cents)) begin
                        rem_nx = change_cents;
                        err_nx = 1'b0;
                    end else begin
                        rem_nx = 7'd0;
                        err_nx = 1'b1;
                    end
                    state_nx = S_SELECT;
                end
            end

            S_SELECT: begin
                if (rem_q == 7'd0) begin
                    state_nx = S_DONE;
                end else begin
                    ej_nx    = pick;
                    state_nx = S_EJECT;
`ifdef COIN_TIMEOUT_EN
                    tmo_nx   = 16'd0;
`endif
                end
            end

            S_EJECT: begin
                if (ej_ack) begin
                    ej_nx    = 3'b000;
                    rem_nx   = (rem_q >= coin_val) ? (rem_q - coin_val) : 7'd0;
                    coins_nx = (coins_q == 4'd15) ? 4'd15 : (coins_q + 4'd1);
                    gap_nx   = 4'd0;
                    state_nx = S_GAP;
                end
`ifdef COIN_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    ej_nx    = 3'b000;
                    err_nx   = 1'b1;
                    state_nx = S_DONE;
                end else begin
                    tmo_nx = tmo_q + 16'd1;
                end
`endif
            end

            S_GAP: begin
                // The next coin is chosen on the last gap cycle so that the
                // ejector sees exactly GAP_CYCLES idle cycles between
                // requests; a separate SELECT cycle would add one more.
                if (gap_q == GAP_LAST) begin
                    if (rem_q == 7'd0) begin
                        state_nx = S_DONE;
                    end else begin
                        ej_nx    = pick;
                        state_nx = S_EJECT;
`ifdef COIN_TIMEOUT_EN
                        tmo_nx   = 16'd0;
`endif
                    end
                end else begin
                    gap_nx = gap_q + 4'd1;
                end
            end

            S_DONE: begin
                state_nx = S_IDLE;
            end

            default: begin
                state_nx = S_IDLE;
                ej_nx    = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            rem_q   <= 7'd0;
            coins_q <= 4'd0;
            err_q   <= 1'b0;
            ej_q    <= 3'b000;
            gap_q   <= 4'd0;
`ifdef COIN_TIMEOUT_EN
            tmo_q   <= 16'd0;
`endif
        end else begin
            state   <= state_nx;
            rem_q   <= rem_nx;
            coins_q <= coins_nx;
            err_q   <= err_nx;
            ej_q    <= ej_nx;
            gap_q   <= gap_nx;
`ifdef COIN_TIMEOUT_EN
            tmo_q   <= tmo_nx;
`endif
        end
    end

    assign ej_quarter = ej_q[2];
    assign ej_dime    = ej_q[1];
    assign ej_nickel  = ej_q[0];
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign err        = err_q;
    assign rem_cents  = rem_q;
    assign coins_out  = coins_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_coin_change_seq.sv
// ---------------------------------------------------------------------------
// tb_coin_change_seq
//
// Directed bench for coin_change_seq with GAP_CYCLES=4, ACK_TIMEOUT=16.
// Each accepted request pushes its expected completion record
// {err, rem_cents, coins_out, coin sequence} into exp_q. A monitor pops and
// compares one record whenever done is seen, and also checks the idle gap
// between coins and that busy falls after done. Coin sequence codes are
// shifted in oldest-first: quarter=3, dime=2, nickel=1.
// ---------------------------------------------------------------------------
module tb_coin_change_seq;

    localparam int GAP = 4;
    localparam int W   = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [6:0] change_cents;
    logic       ej_ack;
    logic       ej_quarter, ej_dime, ej_nickel;
    logic       busy, done, err;
    logic [6:0] rem_cents;
    logic [3:0] coins_out;
    logic [2:0] dbg_state;

    logic [W-1:0] exp_q[$];
    int compare_cnt = 0;
    int fail_cnt    = 0;

    coin_change_seq #(.GAP_CYCLES(GAP), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .start(start), .change_cents(change_cents),
        .ej_ack(ej_ack), .ej_quarter(ej_quarter), .ej_dime(ej_dime),
        .ej_nickel(ej_nickel), .busy(busy), .done(done), .err(err),
        .rem_cents(rem_cents), .coins_out(coins_out), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic check(input string name, input int got, input int exp);
        compare_cnt++;
        if (got != exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rec(input logic e, input logic [6:0] r,
                                         input logic [3:0] c, input logic [7:0] s);
        rec = {e, r, c, s};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic [7:0] seq_m = 8'd0;
    logic       have_coin = 1'b0;
    logic       prev_any = 1'b0;
    logic       done_seen = 1'b0;
    int         low_run = 0;

    always @(negedge clk) begin : monitor
        logic any;
        logic [W-1:0] e;
        any = ej_quarter | ej_dime | ej_nickel;
        if (done_seen) begin
            check("busy_after_done", int'(busy), 0);
            done_seen = 1'b0;
        end
        if (!busy) begin
            seq_m = 8'd0; have_coin = 1'b0; low_run = 0; prev_any = 1'b0;
        end else begin
            if (any && !prev_any) begin
                check("ej_onehot", $countones({ej_quarter, ej_dime, ej_nickel}), 1);
                if (have_coin) check("gap_len", low_run, GAP);
                seq_m = {seq_m[5:0], ej_quarter ? 2'd3 : (ej_dime ? 2'd2 : 2'd1)};
                have_coin = 1'b1;
                low_run = 0;
            end else if (!any && have_coin) begin
                low_run++;
            end
            prev_any = any;
        end
        if (done) begin
            done_seen = 1'b1;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("err",       int'(err),       int'(e[19]));
                check("rem_cents", int'(rem_cents), int'(e[18:12]));
                check("coins_out", int'(coins_out), int'(e[11:8]));
                check("coin_seq",  int'(seq_m),     int'(e[7:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Drives start for one cycle; returns at the following negedge.
    task automatic issue(input logic [6:0] amt, input logic push, input logic [W-1:0] e);
        int n;
        n = 0;
        while (busy && n < 200) begin @(negedge clk); n++; end
        if (busy) check("idle_before_start", 1, 0);
        if (push) exp_q.push_back(e);
        start = 1'b1;
        change_cents = amt;
        @(negedge clk);
        start = 1'b0;
        change_cents = 7'd0;
    endtask

    // Waits (bounded) for any eject request; returns negedges waited.
    task automatic wait_req(output int n);
        n = 0;
        while (!(ej_quarter | ej_dime | ej_nickel) && n < 100) begin
            @(negedge clk); n++;
        end
        if (n >= 100) check("req_timeout", 1, 0);
    endtask

    // Acknowledges one coin `delay` cycles after its request appears, then
    // checks the amount still owed. With disturb, a stray start and ack are
    // driven during the gap that follows.
    task automatic serve_coin(input int delay, input logic disturb, input int exp_rem);
        int n;
        wait_req(n);
        repeat (delay) @(negedge clk);
        ej_ack = 1'b1;
        @(negedge clk);
        check("rem_step", int'(rem_cents), exp_rem);
        if (disturb) begin
            start = 1'b1;
            change_cents = 7'd5;
            @(negedge clk);
            start = 1'b0;
            change_cents = 7'd0;
        end
        ej_ack = 1'b0;
    endtask

    // Payment that must finish without any eject activity.
    task automatic run_no_eject(input logic [6:0] amt, input logic exp_err);
        int k;
        logic seen;
        issue(amt, 1'b1, rec(exp_err, 7'd0, 4'd0, 8'd0));
        k = 1;
        seen = 1'b0;
        while (!done && k < 20) begin
            if (ej_quarter | ej_dime | ej_nickel) seen = 1'b1;
            @(negedge clk); k++;
        end
        check("done_latency", k, 2);
        check("no_eject", int'(seen), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int n;
        int hc;
        reset = 1'b1; start = 1'b0; change_cents = 7'd0; ej_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              int'({ej_quarter, ej_dime, ej_nickel, busy, done, err, rem_cents, coins_out}), 0);
        reset = 1'b0;
        @(negedge clk);

        // 5 cents, ack three cycles after the request
        issue(7'd5, 1'b1, rec(1'b0, 7'd0, 4'd1, 8'h01));
        wait_req(n);
        check("req_latency", n + 1, 2);
        repeat (3) @(negedge clk);
        ej_ack = 1'b1;
        @(negedge clk);
        ej_ack = 1'b0;
        check("rem_after_nickel", int'(rem_cents), 0);

        // 45 cents: quarter, dime, dime
        issue(7'd45, 1'b1, rec(1'b0, 7'd0, 4'd3, 8'h3A));
        serve_coin(2, 1'b0, 20);
        serve_coin(2, 1'b0, 10);
        serve_coin(2, 1'b0, 0);

        // zero and unpayable amounts
        run_no_eject(7'd0, 1'b0);
        run_no_eject(7'd37, 1'b1);
        run_no_eject(7'd105, 1'b1);

        // 100 cents with start and stray acks during every gap
        issue(7'd100, 1'b1, rec(1'b0, 7'd0, 4'd4, 8'hFF));
        serve_coin(1, 1'b1, 75);
        serve_coin(1, 1'b1, 50);
        serve_coin(1, 1'b1, 25);
        serve_coin(1, 1'b1, 0);

        // reset in the middle of a 60-cent eject
        issue(7'd60, 1'b0, '0);
        wait_req(n);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset_mid_eject",
              int'({ej_quarter, ej_dime, ej_nickel, busy, done, err, rem_cents, coins_out}), 0);
        issue(7'd10, 1'b1, rec(1'b0, 7'd0, 4'd1, 8'h02));
        serve_coin(2, 1'b0, 0);

        // 30 cents, ejector never acknowledges
`ifdef COIN_TIMEOUT_EN
        issue(7'd30, 1'b1, rec(1'b1, 7'd30, 4'd0, 8'h03));
        wait_req(n);
        hc = 0;
        while (ej_quarter && hc < 100) begin @(negedge clk); hc++; end
        check("timeout_len", hc, 16);
`else
        issue(7'd30, 1'b0, '0);
        wait_req(n);
        hc = 0;
        while (ej_quarter && hc < 200) begin @(negedge clk); hc++; end
        check("no_timeout_hold", hc, 200);
        check("no_timeout_rem", int'(rem_cents), 30);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset_after_hold", int'({ej_quarter, ej_dime, ej_nickel, busy}), 0);
`endif

        n = 0;
        while (exp_q.size() > 0 && n < 300) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        check("exp_q_left", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, fail_cnt);
        $finish;
    end

endmodule
